// File: rtl/butterfly_pkg.sv
// ---------------------------------------------------------------------------
// butterfly_pkg
// Shared types and constants for the butterfly operand sequencer.
//   drv_state_t   : sequencer states, one per ReadyIn window
//   HOLD_MIN      : shortest legal handshake level hold, in cycles
//   CALC_MIN      : shortest legal calc extension after B and A
//   phase_length(): number of cycles a state is held for a given HOLD/CALC
// ---------------------------------------------------------------------------
package butterfly_pkg;

  localparam int HOLD_MIN = 2;
  localparam int CALC_MIN = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_W_LO,
    ST_W_HI,
    ST_B_LO,
    ST_B_HI,
    ST_A_LO,
    ST_A_HI,
    ST_Y_LO,
    ST_Z_HI,
    ST_Z_LO,
    ST_DONE
  } drv_state_t;

  // IDLE has no length: it is left on start, not on a timer expiry.
  function automatic int phase_length(drv_state_t s, int hold, int calc);
    int len;
    len = 0;
    case (s)
      ST_W_LO, ST_W_HI, ST_B_LO, ST_A_LO,
      ST_Y_LO, ST_Z_HI, ST_Z_LO:          len = hold;
      ST_B_HI, ST_A_HI:                   len = hold + calc;
      ST_DONE:                            len = 1;
      default:                            len = 0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/butterfly_driver_if.sv
// ---------------------------------------------------------------------------
// butterfly_driver_if
// Bundles the host-side request, the operand/result buses and the captured
// results of the butterfly operand sequencer.
//   start            : one-cycle transaction request
//   w_in, b_in, a_in : operands, latched when start is accepted
//   result           : display bus coming back from the butterfly
//   ReadyIn          : handshake level toward the butterfly controller
//   data_out         : operand bus toward the butterfly
//   busy, done       : transaction status
//   re_y .. im_z     : captured results
// master = host/test source side, slave = butterfly_driver side.
// ---------------------------------------------------------------------------
interface butterfly_driver_if #(
  parameter int DW = 8
);

  logic          start;
  logic [DW-1:0] w_in;
  logic [DW-1:0] b_in;
  logic [DW-1:0] a_in;
  logic [DW-1:0] result;
  logic          ReadyIn;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          done;
  logic [DW-1:0] re_y;
  logic [DW-1:0] im_y;
  logic [DW-1:0] re_z;
  logic [DW-1:0] im_z;

  modport master (
    output start, w_in, b_in, a_in, result,
    input  ReadyIn, data_out, busy, done, re_y, im_y, re_z, im_z
  );

  modport slave (
    input  start, w_in, b_in, a_in, result,
    output ReadyIn, data_out, busy, done, re_y, im_y, re_z, im_z
  );

endinterface

// File: rtl/phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
// Down-counter that measures how long the sequencer stays in a state.
//   Clock  : rising-edge clock
//   nReset : asynchronous active-low reset, count returns to 0
//   load   : reload the count with length (asserted on state entry)
//   length : number of cycles of the state being entered
//   last   : high during the final cycle of the phase (count == 1)
// ---------------------------------------------------------------------------
module phase_timer #(
  parameter int W = 3
) (
  input  logic         Clock,
  input  logic         nReset,
  input  logic         load,
  input  logic [W-1:0] length,
  output logic         last
);

  logic [W-1:0] count;

  // The count parks at 0 once it runs out so an unloaded timer never
  // produces a spurious last flag.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
    end else if (load) begin
      count <= length;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/butterfly_driver.sv
// ---------------------------------------------------------------------------
// butterfly_driver
// Operand sequencer for the FFT butterfly. One accepted start walks the
// butterfly controller through W, B and A on a shared operand bus using the
// ReadyIn level handshake, waits out the calc phases, then steps the
// controller through its four display phases, capturing ReY, ImY, ReZ and
// ImZ from the result bus.
//   Clock   : rising-edge clock
//   nReset  : asynchronous active-low reset
//   bus     : butterfly_driver_if slave modport (start, operands, result,
//             ReadyIn, data_out, busy, done, captured results)
// Parameters: DW word width, HOLD cycles per handshake level, CALC extra
// high-level cycles after B and A.
// ---------------------------------------------------------------------------
module butterfly_driver
  import butterfly_pkg::*;
#(
  parameter int DW   = 8,
  parameter int HOLD = 2,
  parameter int CALC = 4
) (
  input  logic             Clock,
  input  logic             nReset,
  butterfly_driver_if.slave bus
);

  localparam int TW = $clog2(HOLD + CALC + 1);

  if (HOLD < HOLD_MIN) begin : g_hold_too_short
    $error("butterfly_driver: HOLD=%0d is below the minimum of %0d", HOLD, HOLD_MIN);
  end

  if (CALC < CALC_MIN) begin : g_calc_too_short
    $error("butterfly_driver: CALC=%0d is below the minimum of %0d", CALC, CALC_MIN);
  end

  drv_state_t    state;
  drv_state_t    next_state;
  logic          accept;
  logic          timer_load;
  logic [TW-1:0] timer_len;
  logic          timer_last;

  logic [DW-1:0] w_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] re_y_q;
  logic [DW-1:0] im_y_q;
  logic [DW-1:0] re_z_q;
  logic [DW-1:0] im_z_q;

  logic          ready_o;
  logic [DW-1:0] data_o;
  logic          busy_o;
  logic          done_o;

  assign accept = (state == ST_IDLE) && bus.start;

  // State register.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: every timed state advances on the timer's last cycle;
  // DONE lasts exactly one cycle and start is only looked at in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (bus.start)  next_state = ST_W_LO;
      ST_W_LO: if (timer_last) next_state = ST_W_HI;
      ST_W_HI: if (timer_last) next_state = ST_B_LO;
      ST_B_LO: if (timer_last) next_state = ST_B_HI;
      ST_B_HI: if (timer_last) next_state = ST_A_LO;
      ST_A_LO: if (timer_last) next_state = ST_A_HI;
      ST_A_HI: if (timer_last) next_state = ST_Y_LO;
      ST_Y_LO: if (timer_last) next_state = ST_Z_HI;
      ST_Z_HI: if (timer_last) next_state = ST_Z_LO;
      ST_Z_LO: if (timer_last) next_state = ST_DONE;
      ST_DONE:                 next_state = ST_IDLE;
      default:                 next_state = ST_IDLE;
    endcase
  end

  // The timer is reloaded with the length of the state being entered on the
  // same edge that enters it, so its count is already valid in the first
  // cycle of the new state.
  assign timer_load = (next_state != state);
  assign timer_len  = TW'(phase_length(next_state, HOLD, CALC));

  phase_timer #(
    .W (TW)
  ) u_phase_timer (
    .Clock  (Clock),
    .nReset (nReset),
    .load   (timer_load),
    .length (timer_len),
    .last   (timer_last)
  );

  // Operands are held locally so the host may change its inputs as soon as
  // start has been accepted.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      w_q <= '0;
      b_q <= '0;
      a_q <= '0;
    end else if (accept) begin
      w_q <= bus.w_in;
      b_q <= bus.b_in;
      a_q <= bus.a_in;
    end
  end

  // Each result is taken on the last cycle of its window, when the
  // controller has been in the matching display state for at least a cycle.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      re_y_q <= '0;
      im_y_q <= '0;
      re_z_q <= '0;
      im_z_q <= '0;
    end else if (timer_last) begin
      case (state)
        ST_A_HI: re_y_q <= bus.result;
        ST_Y_LO: im_y_q <= bus.result;
        ST_Z_HI: re_z_q <= bus.result;
        ST_Z_LO: im_z_q <= bus.result;
        default: ;
      endcase
    end
  end

  // Outputs follow the state alone. data_out carries the same operand for
  // both the low and the high window so the receiver's store strobe always
  // sees a settled word.
  always_comb begin
    ready_o = 1'b1;
    data_o  = '0;
    busy_o  = 1'b1;
    done_o  = 1'b0;
    case (state)
      ST_IDLE: busy_o = 1'b0;
      ST_W_LO: begin ready_o = 1'b0; data_o = w_q; end
      ST_W_HI: data_o = w_q;
      ST_B_LO: begin ready_o = 1'b0; data_o = b_q; end
      ST_B_HI: data_o = b_q;
      ST_A_LO: begin ready_o = 1'b0; data_o = a_q; end
      ST_A_HI: data_o = a_q;
      ST_Y_LO: ready_o = 1'b0;
      ST_Z_HI: ;
      ST_Z_LO: ready_o = 1'b0;
      ST_DONE: begin busy_o = 1'b0; done_o = 1'b1; end
      default: busy_o = 1'b0;
    endcase
  end

  assign bus.ReadyIn  = ready_o;
  assign bus.data_out = data_o;
  assign bus.busy     = busy_o;
  assign bus.done     = done_o;
  assign bus.re_y     = re_y_q;
  assign bus.im_y     = im_y_q;
  assign bus.re_z     = re_z_q;
  assign bus.im_z     = im_z_q;

endmodule

// File: tb/tb_butterfly_driver.sv
// ---------------------------------------------------------------------------
// tb_butterfly_driver
// Drives two butterfly_driver instances (default HOLD/CALC and HOLD=3,
// CALC=5) against a behavioural model of the butterfly controller that
// lags ReadyIn by one cycle, stores W/B/A and presents results on the
// display bus. Transactions come from a vector table; the reset corner is
// a hand-written sequence.
// ---------------------------------------------------------------------------
module tb_butterfly_driver;

  typedef enum logic [4:0] {
    M_IDLE, M_WW, M_RW, M_WBL, M_WBH, M_RB, M_C1, M_C2, M_C3,
    M_WAL, M_WAH, M_RA, M_REY, M_IMY, M_REZ, M_IMZ
  } ctl_t;

  typedef struct {
    int         nw;
    int         nb;
    int         na;
    logic [7:0] vw;
    logic [7:0] vb;
    logic [7:0] va;
  } store_rec_t;

  typedef struct {
    logic       ri;
    logic [7:0] dout;
    logic       busy;
    logic       done;
    logic [7:0] ry;
    logic [7:0] iy;
    logic [7:0] rz;
    logic [7:0] iz;
  } obs_t;

  typedef struct {
    int         dut;
    logic [7:0] w;
    logic [7:0] b;
    logic [7:0] a;
    logic [7:0] ry;
    logic [7:0] iy;
    logic [7:0] rz;
    logic [7:0] iz;
    int         latency;
    int         abs_latency;
    int         pulse_a;
    int         pulse_b;
    int         quiet;
  } vec_t;

  logic Clock  = 1'b0;
  logic nReset = 1'b0;

  always #5 Clock = ~Clock;

  butterfly_driver_if #(.DW(8)) bus0 ();
  butterfly_driver_if #(.DW(8)) bus1 ();

  butterfly_driver #(.DW(8), .HOLD(2), .CALC(4)) dut0 (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus0.slave)
  );

  butterfly_driver #(.DW(8), .HOLD(3), .CALC(5)) dut1 (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus1.slave)
  );

  int pass_count  = 0;
  int total_count = 0;
  int edge_n      = 0;
  int prev_s_edge = 0;

  logic [7:0] rv_ry = 8'h00;
  logic [7:0] rv_iy = 8'h00;
  logic [7:0] rv_rz = 8'h00;
  logic [7:0] rv_iz = 8'h00;

  ctl_t       m0;
  ctl_t       m1;
  store_rec_t rec0 = '{default: 0};
  store_rec_t rec1 = '{default: 0};

  vec_t vecs [5];

  always @(posedge Clock) edge_n <= edge_n + 1;

  // Butterfly controller model: waits for each ReadyIn level change seen one
  // cycle late, stores on the cycle after a rising level, runs three calc
  // cycles after B, and walks the four display states after A.
  function automatic ctl_t ctl_next(ctl_t s, logic ri);
    ctl_t n;
    n = s;
    case (s)
      M_IDLE: n = ri ? M_IDLE : M_WW;
      M_WW:   n = ri ? M_RW   : M_WW;
      M_RW:   n = M_WBL;
      M_WBL:  n = ri ? M_WBL  : M_WBH;
      M_WBH:  n = ri ? M_RB   : M_WBH;
      M_RB:   n = M_C1;
      M_C1:   n = M_C2;
      M_C2:   n = M_C3;
      M_C3:   n = M_WAL;
      M_WAL:  n = ri ? M_WAL  : M_WAH;
      M_WAH:  n = ri ? M_RA   : M_WAH;
      M_RA:   n = M_REY;
      M_REY:  n = ri ? M_REY  : M_IMY;
      M_IMY:  n = ri ? M_REZ  : M_IMY;
      M_REZ:  n = ri ? M_REZ  : M_IMZ;
      M_IMZ:  n = ri ? M_IDLE : M_IMZ;
      default: n = M_IDLE;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] ctl_result(ctl_t s, logic [7:0] ry, logic [7:0] iy,
                                            logic [7:0] rz, logic [7:0] iz);
    logic [7:0] r;
    case (s)
      M_REY:   r = ry;
      M_IMY:   r = iy;
      M_REZ:   r = rz;
      M_IMZ:   r = iz;
      default: r = 8'hFF;
    endcase
    return r;
  endfunction

  assign bus0.result = ctl_result(m0, rv_ry, rv_iy, rv_rz, rv_iz);
  assign bus1.result = ctl_result(m1, rv_ry, rv_iy, rv_rz, rv_iz);

  // Controller model for dut0, with a record of every store strobe.
  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      m0 <= M_IDLE;
    end else begin
      m0 <= ctl_next(m0, bus0.ReadyIn);
      if (m0 == M_RW) begin rec0.nw <= rec0.nw + 1; rec0.vw <= bus0.data_out; end
      if (m0 == M_RB) begin rec0.nb <= rec0.nb + 1; rec0.vb <= bus0.data_out; end
      if (m0 == M_RA) begin rec0.na <= rec0.na + 1; rec0.va <= bus0.data_out; end
    end
  end

  // Controller model for dut1.
  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      m1 <= M_IDLE;
    end else begin
      m1 <= ctl_next(m1, bus1.ReadyIn);
      if (m1 == M_RW) begin rec1.nw <= rec1.nw + 1; rec1.vw <= bus1.data_out; end
      if (m1 == M_RB) begin rec1.nb <= rec1.nb + 1; rec1.vb <= bus1.data_out; end
      if (m1 == M_RA) begin rec1.na <= rec1.na + 1; rec1.va <= bus1.data_out; end
    end
  end

  function automatic obs_t observe(int d);
    obs_t o;
    if (d == 0) begin
      o.ri = bus0.ReadyIn; o.dout = bus0.data_out; o.busy = bus0.busy; o.done = bus0.done;
      o.ry = bus0.re_y;    o.iy = bus0.im_y;       o.rz = bus0.re_z;   o.iz = bus0.im_z;
    end else begin
      o.ri = bus1.ReadyIn; o.dout = bus1.data_out; o.busy = bus1.busy; o.done = bus1.done;
      o.ry = bus1.re_y;    o.iy = bus1.im_y;       o.rz = bus1.re_z;   o.iz = bus1.im_z;
    end
    return o;
  endfunction

  function automatic store_rec_t getRec(int d);
    return (d == 0) ? rec0 : rec1;
  endfunction

  function automatic ctl_t getModel(int d);
    return (d == 0) ? m0 : m1;
  endfunction

  task automatic driveInputs(int d, logic s, logic [7:0] w, logic [7:0] b, logic [7:0] a);
    if (d == 0) begin
      bus0.start = s; bus0.w_in = w; bus0.b_in = b; bus0.a_in = a;
    end else begin
      bus1.start = s; bus1.w_in = w; bus1.b_in = b; bus1.a_in = a;
    end
  endtask

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    total_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Runs one full transaction from an idle cycle and ends in the idle cycle
  // that follows DONE.
  task automatic applyStimulus(vec_t v, int idx);
    obs_t       o;
    store_rec_t r0;
    store_rec_t r1;
    int         cyc;
    int         s_edge;
    int         busy_gaps;
    int         noise;
    bit         seen;

    rv_ry = v.ry; rv_iy = v.iy; rv_rz = v.rz; rv_iz = v.iz;
    r0 = getRec(v.dut);
    driveInputs(v.dut, 1'b1, v.w, v.b, v.a);
    @(posedge Clock); #1;
    s_edge = edge_n;
    driveInputs(v.dut, 1'b0, ~v.w, ~v.b, ~v.a);
    cyc = 1;

    o = observe(v.dut);
    checkOutput($sformatf("v%0d_wlo_readyin", idx), 32'(o.ri), 32'd0);
    checkOutput($sformatf("v%0d_wlo_data", idx), 32'(o.dout), 32'(v.w));

    busy_gaps = 0;
    seen      = 1'b0;
    while (!seen && cyc < 200) begin
      o = observe(v.dut);
      if (o.done) begin
        seen = 1'b1;
      end else begin
        if (!o.busy) busy_gaps++;
        @(posedge Clock); #1;
        cyc++;
        driveInputs(v.dut, (cyc == v.pulse_a) || (cyc == v.pulse_b), 8'hEE, 8'hDD, 8'hCC);
      end
    end

    checkOutput($sformatf("v%0d_done_cycle", idx), 32'(cyc), 32'(v.latency));
    checkOutput($sformatf("v%0d_busy_gaps", idx), 32'(busy_gaps), 32'd0);
    checkOutput($sformatf("v%0d_busy_in_done", idx), 32'(o.busy), 32'd0);
    if (v.abs_latency != 0)
      checkOutput($sformatf("v%0d_b2b_done_cycle", idx), 32'(edge_n - prev_s_edge + 1),
                  32'(v.abs_latency));
    prev_s_edge = s_edge;

    checkOutput($sformatf("v%0d_re_y", idx), 32'(o.ry), 32'(v.ry));
    checkOutput($sformatf("v%0d_im_y", idx), 32'(o.iy), 32'(v.iy));
    checkOutput($sformatf("v%0d_re_z", idx), 32'(o.rz), 32'(v.rz));
    checkOutput($sformatf("v%0d_im_z", idx), 32'(o.iz), 32'(v.iz));

    r1 = getRec(v.dut);
    checkOutput($sformatf("v%0d_store_w_count", idx), 32'(r1.nw - r0.nw), 32'd1);
    checkOutput($sformatf("v%0d_store_b_count", idx), 32'(r1.nb - r0.nb), 32'd1);
    checkOutput($sformatf("v%0d_store_a_count", idx), 32'(r1.na - r0.na), 32'd1);
    checkOutput($sformatf("v%0d_store_w_value", idx), 32'(r1.vw), 32'(v.w));
    checkOutput($sformatf("v%0d_store_b_value", idx), 32'(r1.vb), 32'(v.b));
    checkOutput($sformatf("v%0d_store_a_value", idx), 32'(r1.va), 32'(v.a));

    @(posedge Clock); #1;
    driveInputs(v.dut, 1'b0, 8'h00, 8'h00, 8'h00);
    o = observe(v.dut);
    checkOutput($sformatf("v%0d_idle_readyin", idx), 32'(o.ri), 32'd1);
    checkOutput($sformatf("v%0d_idle_busy", idx), 32'(o.busy), 32'd0);
    checkOutput($sformatf("v%0d_idle_done", idx), 32'(o.done), 32'd0);
    checkOutput($sformatf("v%0d_model_idle", idx), 32'(getModel(v.dut)), 32'(M_IDLE));

    if (v.quiet > 0) begin
      noise = 0;
      for (int k = 0; k < v.quiet; k++) begin
        @(posedge Clock); #1;
        o = observe(v.dut);
        if (o.busy || o.done) noise++;
      end
      checkOutput($sformatf("v%0d_no_extra_txn", idx), 32'(noise), 32'd0);
    end
  endtask

  initial begin
    obs_t o;
    int   cyc;

    //          dut  W      B      A      ReY    ImY    ReZ    ImZ   lat abs p_a p_b quiet
    vecs[0] = '{0, 8'h12, 8'h34, 8'h56, 8'h11, 8'h22, 8'h33, 8'h44, 27,  0,  0,  0, 0};
    vecs[1] = '{0, 8'h9C, 8'h3E, 8'h71, 8'h55, 8'h66, 8'h77, 8'h88, 27, 55,  0,  0, 0};
    vecs[2] = '{0, 8'hC8, 8'h0F, 8'hE1, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 27,  0,  5, 27, 4};
    vecs[3] = '{1, 8'h21, 8'h43, 8'h65, 8'h19, 8'h28, 8'h37, 8'h46, 38,  0,  0,  0, 0};
    vecs[4] = '{0, 8'hA1, 8'hB2, 8'hC3, 8'h0D, 8'h1E, 8'h2F, 8'h30, 27,  0,  0,  0, 0};

    driveInputs(0, 1'b0, 8'h00, 8'h00, 8'h00);
    driveInputs(1, 1'b0, 8'h00, 8'h00, 8'h00);
    nReset = 1'b0;
    repeat (3) @(posedge Clock);
    #1;

    o = observe(0);
    checkOutput("reset_readyin", 32'(o.ri), 32'd1);
    checkOutput("reset_data_out", 32'(o.dout), 32'd0);
    checkOutput("reset_busy", 32'(o.busy), 32'd0);
    checkOutput("reset_done", 32'(o.done), 32'd0);
    checkOutput("reset_captures", {o.ry, o.iy, o.rz, o.iz}, 32'd0);
    o = observe(1);
    checkOutput("reset_readyin_dut1", 32'(o.ri), 32'd1);

    @(negedge Clock) nReset = 1'b1;
    @(posedge Clock); #1;

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i], i);

    // Reset in the middle of A_HI, then a fresh transaction.
    $display("[TB] reset during A_HI");
    rv_ry = 8'h01; rv_iy = 8'h02; rv_rz = 8'h03; rv_iz = 8'h04;
    driveInputs(0, 1'b1, 8'h9A, 8'hBC, 8'hDE);
    @(posedge Clock); #1;
    driveInputs(0, 1'b0, 8'h00, 8'h00, 8'h00);
    cyc = 1;
    while (cyc < 16) begin
      @(posedge Clock); #1;
      cyc++;
    end
    o = observe(0);
    checkOutput("rst_pre_busy", 32'(o.busy), 32'd1);
    checkOutput("rst_pre_readyin", 32'(o.ri), 32'd1);
    checkOutput("rst_pre_data_out", 32'(o.dout), 32'hDE);
    nReset = 1'b0;
    #1;
    o = observe(0);
    checkOutput("rst_readyin", 32'(o.ri), 32'd1);
    checkOutput("rst_data_out", 32'(o.dout), 32'd0);
    checkOutput("rst_busy", 32'(o.busy), 32'd0);
    checkOutput("rst_done", 32'(o.done), 32'd0);
    checkOutput("rst_re_y", 32'(o.ry), 32'd0);
    checkOutput("rst_im_y", 32'(o.iy), 32'd0);
    checkOutput("rst_re_z", 32'(o.rz), 32'd0);
    checkOutput("rst_im_z", 32'(o.iz), 32'd0);
    checkOutput("rst_model_idle", 32'(m0), 32'(M_IDLE));
    repeat (2) @(posedge Clock);
    @(negedge Clock) nReset = 1'b1;
    @(posedge Clock); #1;

    applyStimulus(vecs[4], 4);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
